// File: rtl/mips_store_unit.sv
// rtl/mips_store_unit.sv - MIPS SB/SH/SW/SWL/SWR store unit driving an Avalon-style write port.
// Optional macro STORE_ALIGN_FAULT_EN: misaligned SH/SW fault instead of being forced aligned.
module mips_store_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [31:0] address,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        done,
  output logic        fault
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       address_q;
  logic [31:0]       writedata_q;
  logic [3:0]        byteenable_q;
  logic              done_q;
  logic              fault_q;

  logic [1:0]        k;
  logic [1:0]        k_half;
  logic [3:0]        lane_be;
  logic [31:0]       lane_data;
  logic              lane_ok;
  logic              take;
  logic              accept;
  logic              expire;

  assign k      = req_addr[1:0];
  assign k_half = {req_addr[1], 1'b0};

  // Lane steering for the incoming request; lane_ok=0 means reject with fault.
  always_comb begin
    lane_be   = 4'b0000;
    lane_data = req_data;
    lane_ok   = 1'b1;
    case (req_op)
      3'b000: begin
        lane_be   = 4'b0001 << k;
        lane_data = {4{req_data[7:0]}};
      end
      3'b001: begin
`ifdef STORE_ALIGN_FAULT_EN
        lane_ok   = ~req_addr[0];
`endif
        lane_be   = 4'b0011 << k_half;
        lane_data = {2{req_data[15:0]}};
      end
      3'b010: begin
`ifdef STORE_ALIGN_FAULT_EN
        lane_ok   = (k == 2'b00);
`endif
        lane_be   = 4'b1111;
        lane_data = req_data;
      end
      3'b011: begin
        lane_be   = 4'((5'b00010 << k) - 5'd1);
        lane_data = req_data >> {2'(2'd3 - k), 3'b000};
      end
      3'b100: begin
        lane_be   = 4'b1111 << k;
        lane_data = req_data << {k, 3'b000};
      end
      default: lane_ok = 1'b0;
    endcase
  end

  assign take   = (state == IDLE) && req_valid;
  assign accept = (state == WRITE) && !waitrequest;
  // Accept is checked first by construction: expire requires waitrequest=1.
  assign expire = (state == WRITE) && waitrequest && (TIMEOUT > 0) &&
                  (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state   <= state_next;
      done_q  <= accept;
      fault_q <= (take && !lane_ok) || expire;
      if (take && lane_ok) begin
        address_q    <= {req_addr[31:2], 2'b00};
        writedata_q  <= lane_data;
        byteenable_q <= lane_be;
        cnt          <= '0;
      end else if ((state == WRITE) && waitrequest) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take && lane_ok) state_next = WRITE;
      WRITE:   if (accept || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    write      = (state == WRITE);
    address    = address_q;
    writedata  = writedata_q;
    byteenable = byteenable_q;
    done       = done_q;
    fault      = fault_q;
  end

endmodule

// File: tb/tb_mips_store_unit.sv
// tb/tb_mips_store_unit.sv - directed-vector bench for mips_store_unit.
// A second instance with TIMEOUT=4 exercises the abort path.
module tb_mips_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, t_req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_data;
  logic        waitrequest, t_waitrequest;

  logic        req_ready, write, done, fault;
  logic [31:0] address, writedata;
  logic [3:0]  byteenable;
  logic        t_req_ready, t_write, t_done, t_fault;
  logic [31:0] t_address, t_writedata;
  logic [3:0]  t_byteenable;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_store_unit u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .address(address), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .done(done), .fault(fault)
  );

  mips_store_unit #(.TIMEOUT(4), .CNT_W(7)) u_dut_to (
    .clk(clk), .reset(reset), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .address(t_address), .write(t_write), .waitrequest(t_waitrequest),
    .writedata(t_writedata), .byteenable(t_byteenable), .done(t_done), .fault(t_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
  endtask

  // Zero-wait store: write at N+1, done at N+2.
  task automatic store0(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ea, input logic [3:0] ebe,
                        input logic [31:0] ed);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    waitrequest = 1'b0;
    drive(op, a, d);
    tick();
    req_valid = 1'b0;
    check({tag, "_write"}, 32'(write), 32'd1);
    check({tag, "_addr"}, address, ea);
    check({tag, "_be"}, 32'(byteenable), 32'(ebe));
    check({tag, "_data"}, writedata & lane_mask(ebe), ed & lane_mask(ebe));
    check({tag, "_nodone"}, 32'(done), 32'd0);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_nofault"}, 32'(fault), 32'd0);
    check({tag, "_wdrop"}, 32'(write), 32'd0);
  endtask

  task automatic reject(input string tag, input logic [2:0] op, input logic [31:0] a);
    drive(op, a, 32'h1234_5678);
    tick();
    req_valid = 1'b0;
    check({tag, "_fault"}, 32'(fault), 32'd1);
    check({tag, "_nowrite"}, 32'(write), 32'd0);
    check({tag, "_nodone"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    check({tag, "_fault_clr"}, 32'(fault), 32'd0);
    check({tag, "_nowrite2"}, 32'(write), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; t_req_valid = 1'b0;
    req_op = 3'b000; req_addr = '0; req_data = '0;
    waitrequest = 1'b0; t_waitrequest = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_write", 32'(write), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_addr", address, 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_be", 32'(byteenable), 32'd0);
    reset = 1'b0;
    tick();

    store0("swl102", 3'b011, 32'h0000_0102, 32'hAABB_CCDD, 32'h0000_0100, 4'b0111, 32'h00AA_BBCC);
    store0("swr101", 3'b100, 32'h0000_0101, 32'hAABB_CCDD, 32'h0000_0100, 4'b1110, 32'hBBCC_DD00);
    store0("sb103",  3'b000, 32'h0000_0103, 32'h1234_56EF, 32'h0000_0100, 4'b1000, 32'hEF00_0000);
    store0("sb100",  3'b000, 32'h0000_0100, 32'h1234_5699, 32'h0000_0100, 4'b0001, 32'h0000_0099);
    store0("sh302",  3'b001, 32'h0000_0302, 32'hDEAD_BEEF, 32'h0000_0300, 4'b1100, 32'hBEEF_0000);
    store0("sw400",  3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D);
    store0("swl103", 3'b011, 32'h0000_0103, 32'h0102_0304, 32'h0000_0100, 4'b1111, 32'h0102_0304);
    store0("swl100", 3'b011, 32'h0000_0100, 32'h0102_0304, 32'h0000_0100, 4'b0001, 32'h0000_0001);
    store0("swr100", 3'b100, 32'h0000_0100, 32'h0102_0304, 32'h0000_0100, 4'b1111, 32'h0102_0304);
    store0("swr103", 3'b100, 32'h0000_0103, 32'h0102_0304, 32'h0000_0100, 4'b1000, 32'h0400_0000);

    // Back-to-back: new request accepted in the same cycle done pulses.
    waitrequest = 1'b0;
    drive(3'b010, 32'h0000_0500, 32'h1111_2222);
    tick();
    tick();
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_ready", 32'(req_ready), 32'd1);
    drive(3'b010, 32'h0000_0504, 32'h3333_4444);
    tick();
    req_valid = 1'b0;
    check("b2b_write", 32'(write), 32'd1);
    check("b2b_addr", address, 32'h0000_0504);
    check("b2b_data", writedata, 32'h3333_4444);
    tick();
    check("b2b_done2", 32'(done), 32'd1);
    tick();

    // Five stalled cycles then accept: outputs stable for six write cycles.
    waitrequest = 1'b1;
    drive(3'b010, 32'h0000_0200, 32'h5A5A_A5A5);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) waitrequest = 1'b0;
      check("stall_write", 32'(write), 32'd1);
      check("stall_addr", address, 32'h0000_0200);
      check("stall_data", writedata, 32'h5A5A_A5A5);
      check("stall_be", 32'(byteenable), 32'hF);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_nodone", 32'(done), 32'd0);
      check("stall_nofault", 32'(fault), 32'd0);
      tick();
    end
    check("stall_done", 32'(done), 32'd1);
    check("stall_wdrop", 32'(write), 32'd0);
    tick();
    check("stall_done_clr", 32'(done), 32'd0);

`ifdef STORE_ALIGN_FAULT_EN
    reject("sh0ff", 3'b001, 32'h0000_00FF);
    reject("sw201", 3'b010, 32'h0000_0201);
`else
    store0("sh0ff", 3'b001, 32'h0000_00FF, 32'h0000_ABCD, 32'h0000_00FC, 4'b1100, 32'hABCD_0000);
    store0("sw201", 3'b010, 32'h0000_0201, 32'h7654_3210, 32'h0000_0200, 4'b1111, 32'h7654_3210);
`endif

    reject("op110", 3'b110, 32'h0000_0100);
    reject("op101", 3'b101, 32'h0000_0100);

    // Timeout instance: waitrequest stuck high, write held for four cycles.
    t_waitrequest = 1'b1;
    t_req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h0000_0600; req_data = 32'h0F0F_0F0F;
    tick();
    t_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_write", 32'(t_write), 32'd1);
      check("to_nofault", 32'(t_fault), 32'd0);
      tick();
    end
    check("to_wdrop", 32'(t_write), 32'd0);
    check("to_fault", 32'(t_fault), 32'd1);
    check("to_nodone", 32'(t_done), 32'd0);
    check("to_ready", 32'(t_req_ready), 32'd1);
    t_waitrequest = 1'b0;
    t_req_valid = 1'b1; req_addr = 32'h0000_0604;
    tick();
    t_req_valid = 1'b0;
    check("to_next_write", 32'(t_write), 32'd1);
    check("to_next_addr", t_address, 32'h0000_0604);
    check("to_fault_clr", 32'(t_fault), 32'd0);
    tick();
    check("to_next_done", 32'(t_done), 32'd1);
    check("to_next_nofault", 32'(t_fault), 32'd0);

    // Accept on the limit edge: done wins over fault.
    t_waitrequest = 1'b1;
    t_req_valid = 1'b1; req_addr = 32'h0000_0608;
    tick();
    t_req_valid = 1'b0;
    tick(); tick(); tick();
    t_waitrequest = 1'b0;
    check("lim_write", 32'(t_write), 32'd1);
    tick();
    check("lim_done", 32'(t_done), 32'd1);
    check("lim_nofault", 32'(t_fault), 32'd0);
    tick();

    // Reset mid-write: store abandoned, no pulse.
    waitrequest = 1'b1;
    drive(3'b010, 32'h0000_0700, 32'h8888_9999);
    tick();
    req_valid = 1'b0;
    tick();
    check("rmw_write", 32'(write), 32'd1);
    reset = 1'b1;
    tick();
    check("rmw_wdrop", 32'(write), 32'd0);
    check("rmw_ready", 32'(req_ready), 32'd1);
    check("rmw_done", 32'(done), 32'd0);
    check("rmw_fault", 32'(fault), 32'd0);
    check("rmw_addr", address, 32'd0);
    check("rmw_wdata", writedata, 32'd0);
    check("rmw_be", 32'(byteenable), 32'd0);
    reset = 1'b0;
    waitrequest = 1'b0;
    tick();
    check("rmw_after_done", 32'(done), 32'd0);
    check("rmw_after_fault", 32'(fault), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
